fp_operand_unpack_seq: RTL and testbench

Operand unpack sequencer for the RVF32 FPU issue path. Accepts an instruction's 1–3 single-precision source operands in one handshake. Time-shares a single `fp_class` classifier to classify and unpack them serially, one per cycle. Returns the whole bundle (class flags, unbiased exponent, normalized significand per operand, plus NaN summaries) to the execute stage through a valid/ready handshake.

---
 rtl/fp_operand_unpack_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_fp_operand_unpack_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_unpack_seq.sv
// Operand unpack sequencer: captures up to three single-precision operands and
// classifies/unpacks them one per cycle through a single shared fp_class.

module fp_class #(
    parameter int NEXP = 8,
    parameter int NSIG = 23
) (
    input  logic [NEXP+NSIG:0]      op,
    output logic [9:0]              flags,
    output logic signed [NEXP+1:0]  exp,
    output logic [NSIG:0]           sig
);
    localparam int EW   = NEXP + 2;
    localparam int SW   = NSIG + 1;
    localparam int LZW  = $clog2(NSIG + 1);
    localparam int BIAS = (1 << (NEXP - 1)) - 1;

    logic            sgn;
    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    logic            e_max, e_zero, f_zero;
    logic            is_nan, is_inf, is_zero, is_sub, is_norm;
    logic [LZW-1:0]  lz;

    assign sgn = op[NEXP+NSIG];
    assign e   = op[NEXP+NSIG-1:NSIG];
    assign f   = op[NSIG-1:0];

    assign e_max   = &e;
    assign e_zero  = ~|e;
    assign f_zero  = ~|f;
    assign is_nan  = e_max & ~f_zero;
    assign is_inf  = e_max & f_zero;
    assign is_zero = e_zero & f_zero;
    assign is_sub  = e_zero & ~f_zero;
    assign is_norm = ~e_max & ~e_zero;

    // Quiet/signalling NaN is decided by the top fraction bit; the rest are split by sign.
    always_comb begin
        flags    = '0;
        flags[0] = is_nan & ~f[NSIG-1];
        flags[1] = is_nan & f[NSIG-1];
        flags[2] = is_inf & ~sgn;
        flags[3] = is_inf & sgn;
        flags[4] = is_zero & ~sgn;
        flags[5] = is_zero & sgn;
        flags[6] = is_sub & ~sgn;
        flags[7] = is_sub & sgn;
        flags[8] = is_norm & ~sgn;
        flags[9] = is_norm & sgn;
    end

    // Leading-zero count of the fraction; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (f[i]) begin
                lz = LZW'(NSIG - 1 - i);
            end
        end
    end

    // Subnormals are renormalised so the leading one lands in the hidden-bit position.
    always_comb begin
        exp = $signed({2'b00, e});
        sig = {1'b1, f};
        if (is_norm) begin
            exp = $signed({2'b00, e}) - $signed(EW'(BIAS));
        end else if (is_sub) begin
            exp = -$signed(EW'(BIAS)) - $signed(EW'(lz));
            sig = SW'({1'b0, f} << (lz + 1'b1));
        end
    end
endmodule

module fp_operand_unpack_seq #(
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    parameter int TAGW = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_nops,
    input  logic [NEXP+NSIG:0]      in_a,
    input  logic [NEXP+NSIG:0]      in_b,
    input  logic [NEXP+NSIG:0]      in_c,
    input  logic [TAGW-1:0]         in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAGW-1:0]         out_tag,
    output logic [1:0]              out_nops,
    output logic [9:0]              out_flags_a,
    output logic [9:0]              out_flags_b,
    output logic [9:0]              out_flags_c,
    output logic signed [NEXP+1:0]  out_exp_a,
    output logic signed [NEXP+1:0]  out_exp_b,
    output logic signed [NEXP+1:0]  out_exp_c,
    output logic [NSIG:0]           out_sig_a,
    output logic [NSIG:0]           out_sig_b,
    output logic [NSIG:0]           out_sig_c,
    output logic                    out_snan_any,
    output logic                    out_nan_any
);
    localparam int W  = NEXP + NSIG + 1;
    localparam int EW = NEXP + 2;
    localparam int SW = NSIG + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    op_a, op_b, op_c, cls_op;
    logic [TAGW-1:0] tag_q;
    logic [1:0]      nops_q, idx, nops_eff;
    logic [9:0]      flags_q [3];
    logic [EW-1:0]   exp_q [3];
    logic [SW-1:0]   sig_q [3];
    logic            snan_q, nan_q;
    logic [9:0]      cls_flags;
    logic signed [EW-1:0] cls_exp;
    logic [SW-1:0]   cls_sig;
    logic            accept, last;

    assign accept   = in_valid & in_ready;
    assign last     = (idx == nops_q - 2'd1);
    assign nops_eff = (in_nops == 2'd0) ? 2'd1 : in_nops;

    always_comb begin
        case (idx)
            2'd0:    cls_op = op_a;
            2'd1:    cls_op = op_b;
            default: cls_op = op_c;
        endcase
    end

    fp_class #(
        .NEXP (NEXP),
        .NSIG (NSIG)
    ) u_class (
        .op    (cls_op),
        .flags (cls_flags),
        .exp   (cls_exp),
        .sig   (cls_sig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Flush overrides every transition, including a DONE hand-off into a new request.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CLS;
            CLS:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = accept ? CLS : IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = ~flush;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~flush;
            end
            default: ;
        endcase
    end

    // Capture wipes every slot so unused ones read as zero; CLS fills one slot per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_c   <= '0;
            tag_q  <= '0;
            nops_q <= '0;
            idx    <= '0;
            snan_q <= 1'b0;
            nan_q  <= 1'b0;
            for (int s = 0; s < 3; s++) begin
                flags_q[s] <= '0;
                exp_q[s]   <= '0;
                sig_q[s]   <= '0;
            end
        end else if (accept) begin
            op_a   <= in_a;
            op_b   <= in_b;
            op_c   <= in_c;
            tag_q  <= in_tag;
            nops_q <= nops_eff;
            idx    <= '0;
            snan_q <= 1'b0;
            nan_q  <= 1'b0;
            for (int s = 0; s < 3; s++) begin
                flags_q[s] <= '0;
                exp_q[s]   <= '0;
                sig_q[s]   <= '0;
            end
        end else if (state == CLS && !flush) begin
            for (int s = 0; s < 3; s++) begin
                if (idx == 2'(s)) begin
                    flags_q[s] <= cls_flags;
                    exp_q[s]   <= cls_exp;
                    sig_q[s]   <= cls_sig;
                end
            end
            snan_q <= snan_q | cls_flags[0];
            nan_q  <= nan_q | cls_flags[0] | cls_flags[1];
            if (!last) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign out_tag      = tag_q;
    assign out_nops     = nops_q;
    assign out_flags_a  = flags_q[0];
    assign out_flags_b  = flags_q[1];
    assign out_flags_c  = flags_q[2];
    assign out_exp_a    = exp_q[0];
    assign out_exp_b    = exp_q[1];
    assign out_exp_c    = exp_q[2];
    assign out_sig_a    = sig_q[0];
    assign out_sig_b    = sig_q[1];
    assign out_sig_c    = sig_q[2];
    assign out_snan_any = snan_q;
    assign out_nan_any  = nan_q;
endmodule

// File: tb/tb_fp_operand_unpack_seq.sv
// Self-checking bench for fp_operand_unpack_seq: directed scenarios followed by
// randomized operand bundles compared against an arithmetic reference model.

module tb_fp_operand_unpack_seq;
    localparam int NEXP = 8;
    localparam int NSIG = 23;
    localparam int TAGW = 5;

    logic               clk = 1'b0;
    logic               rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]         in_nops, out_nops;
    logic [31:0]        in_a, in_b, in_c;
    logic [TAGW-1:0]    in_tag, out_tag;
    logic [9:0]         out_flags_a, out_flags_b, out_flags_c;
    logic signed [9:0]  out_exp_a, out_exp_b, out_exp_c;
    logic [23:0]        out_sig_a, out_sig_b, out_sig_c;
    logic               out_snan_any, out_nan_any;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]         e_flags [3];
    logic signed [9:0]  e_exp [3];
    logic [23:0]        e_sig [3];
    logic               e_snan, e_nan;
    logic [TAGW-1:0]    e_tag;
    logic [1:0]         e_nops;

    always #5 clk = ~clk;

    fp_operand_unpack_seq #(
        .NEXP (NEXP),
        .NSIG (NSIG),
        .TAGW (TAGW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_nops      (in_nops),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_nops     (out_nops),
        .out_flags_a  (out_flags_a),
        .out_flags_b  (out_flags_b),
        .out_flags_c  (out_flags_c),
        .out_exp_a    (out_exp_a),
        .out_exp_b    (out_exp_b),
        .out_exp_c    (out_exp_c),
        .out_sig_a    (out_sig_a),
        .out_sig_b    (out_sig_b),
        .out_sig_c    (out_sig_c),
        .out_snan_any (out_snan_any),
        .out_nan_any  (out_nan_any)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    // Value-level reference: the significand is doubled until it reaches 2^23.
    function automatic void model(input logic [31:0] x, output logic [9:0] fl,
                                  output logic signed [9:0] ex, output logic [23:0] sg);
        int s, e, f, m, ee;
        s  = int'(x[31]);
        e  = int'(x[30:23]);
        f  = int'(x[22:0]);
        fl = '0;
        if (e == 255) begin
            ex = 10'sd255;
            sg = 24'(f + (1 << 23));
            if (f == 0) fl[(s == 1) ? 3 : 2] = 1'b1;
            else if (f >= (1 << 22)) fl[1] = 1'b1;
            else fl[0] = 1'b1;
        end else if (e == 0 && f == 0) begin
            ex = 10'sd0;
            sg = 24'h800000;
            fl[(s == 1) ? 5 : 4] = 1'b1;
        end else begin
            m  = (e == 0) ? f : f + (1 << 23);
            ee = (e == 0) ? -126 : e - 127;
            while (m < (1 << 23)) begin
                m  = m * 2;
                ee = ee - 1;
            end
            ex = 10'(ee);
            sg = 24'(m);
            if (e == 0) fl[(s == 1) ? 7 : 6] = 1'b1;
            else fl[(s == 1) ? 9 : 8] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] randOperand();
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        e = 8'd0;
        case ($urandom_range(0, 5))
            0: f = '0;
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 0) f = 23'd1;
            end
            2: e = 8'($urandom_range(1, 254));
            3: begin e = 8'hFF; f = '0; end
            4: begin e = 8'hFF; f[22] = 1'b1; end
            default: begin
                e = 8'hFF;
                f[22] = 1'b0;
                if (f == 0) f = 23'd1;
            end
        endcase
        return {s, e, f};
    endfunction

    // Waits for in_ready, presents one request for one edge and records the expected bundle.
    task automatic applyStimulus(input logic [1:0] nops, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [TAGW-1:0] tag);
        int lim;
        logic [1:0]  n_eff;
        logic [31:0] op;
        lim = 0;
        #1;
        while (in_ready !== 1'b1 && lim < 20) begin
            @(negedge clk);
            #1;
            lim++;
        end
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        in_nops  = nops;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_tag   = tag;
        in_valid = 1'b1;
        n_eff  = (nops == 2'd0) ? 2'd1 : nops;
        e_nops = n_eff;
        e_tag  = tag;
        e_snan = 1'b0;
        e_nan  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op = (k == 0) ? a : ((k == 1) ? b : c);
            if (k < int'(n_eff)) begin
                model(op, e_flags[k], e_exp[k], e_sig[k]);
                e_snan = e_snan | e_flags[k][0];
                e_nan  = e_nan | e_flags[k][0] | e_flags[k][1];
            end else begin
                e_flags[k] = '0;
                e_exp[k]   = '0;
                e_sig[k]   = '0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_c     = $urandom;
        in_tag   = TAGW'($urandom);
        in_nops  = 2'($urandom);
    endtask

    task automatic checkBundle(input string name);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_tag"}, 32'(out_tag), 32'(e_tag));
        check({name, "_nops"}, 32'(out_nops), 32'(e_nops));
        check({name, "_flags_a"}, 32'(out_flags_a), 32'(e_flags[0]));
        check({name, "_flags_b"}, 32'(out_flags_b), 32'(e_flags[1]));
        check({name, "_flags_c"}, 32'(out_flags_c), 32'(e_flags[2]));
        check({name, "_exp_a"}, out_exp_a, e_exp[0]);
        check({name, "_exp_b"}, out_exp_b, e_exp[1]);
        check({name, "_exp_c"}, out_exp_c, e_exp[2]);
        check({name, "_sig_a"}, 32'(out_sig_a), 32'(e_sig[0]));
        check({name, "_sig_b"}, 32'(out_sig_b), 32'(e_sig[1]));
        check({name, "_sig_c"}, 32'(out_sig_c), 32'(e_sig[2]));
        check({name, "_snan_any"}, {31'b0, out_snan_any}, {31'b0, e_snan});
        check({name, "_nan_any"}, {31'b0, out_nan_any}, {31'b0, e_nan});
    endtask

    // Counts negedges after the accepting edge until out_valid; must equal the operand count.
    task automatic checkOutput(input string name);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(e_nops));
        checkBundle(name);
    endtask

    task automatic checkZero(input string name);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd0);
        check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({name, "_tag"}, 32'(out_tag), 32'd0);
        check({name, "_nops"}, 32'(out_nops), 32'd0);
        check({name, "_flags"}, {2'b0, out_flags_a, out_flags_b, out_flags_c}, 32'd0);
        check({name, "_exp_a"}, out_exp_a, 32'd0);
        check({name, "_exp_b"}, out_exp_b, 32'd0);
        check({name, "_exp_c"}, out_exp_c, 32'd0);
        check({name, "_sig_a"}, 32'(out_sig_a), 32'd0);
        check({name, "_sig_b"}, 32'(out_sig_b), 32'd0);
        check({name, "_sig_c"}, 32'(out_sig_c), 32'd0);
        check({name, "_summary"}, {30'b0, out_snan_any, out_nan_any}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bp;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_nops   = 2'd0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_tag    = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready_during", {31'b0, in_ready}, 32'd1);
        check("rst_valid_during", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkZero("rst");

        applyStimulus(2'd1, 32'h3F800000, 32'h12345678, 32'h7F800001, 5'd7);
        checkOutput("t1");
        check("t1_flags_a_const", 32'(out_flags_a), 32'h100);
        check("t1_sig_a_const", 32'(out_sig_a), 32'h800000);

        applyStimulus(2'd3, 32'h00000001, 32'h7F800001, 32'h80000000, 5'd12);
        checkOutput("t2");
        check("t2_exp_a_const", out_exp_a, -32'sd149);
        check("t2_flags_b_const", 32'(out_flags_b), 32'h001);
        check("t2_flags_c_const", 32'(out_flags_c), 32'h020);

        applyStimulus(2'd2, 32'h7FC00000, 32'hFF800000, 32'h7F800001, 5'd3);
        checkOutput("t3");
        check("t3_snan_const", {31'b0, out_snan_any}, 32'd0);
        check("t3_flags_c_const", 32'(out_flags_c), 32'd0);

        applyStimulus(2'd0, 32'hC0490FDB, 32'h7F800001, 32'h00400000, 5'd21);
        checkOutput("t4_nops0");

        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(2'd2, 32'h00400000, 32'hBF000000, 32'h0, 5'd9);
        checkOutput("bp");
        repeat (5) begin
            @(negedge clk);
            checkBundle("bp_hold");
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus(2'd1, 32'h80000001, 32'h0, 32'h0, 5'd30);
        check("b2b_gap", {31'b0, out_valid}, 32'd0);
        checkOutput("b2b");

        applyStimulus(2'd3, 32'h40000000, 32'h7F800001, 32'hFFC00001, 5'd17);
        @(negedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_idle_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("flush_no_bundle", {31'b0, out_valid}, 32'd0);
        end
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_nops  = 2'd1;
        #1 check("flush_gates_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_no_capture", {31'b0, out_valid}, 32'd0);
        applyStimulus(2'd1, 32'h3FC00000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
        checkOutput("post_flush");

        out_ready = 1'b0;
        check("rstmid_valid_before", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 checkZero("rstmid");

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(2'($urandom_range(0, 3)), randOperand(), randOperand(), randOperand(),
                          TAGW'($urandom));
            bp = $urandom_range(0, 3);
            if (bp > 0) out_ready = 1'b0;
            checkOutput("rnd");
            repeat (bp) begin
                @(negedge clk);
                checkBundle("rnd_hold");
            end
            out_ready = 1'b1;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
